// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch cache.
//   t_fetch_state : fetch FSM state encoding
//   RESET_VECTOR  : CPU reset PC
//   HALT_ADDR     : PC value that means "CPU halted"; it is served as a NOP-like 0 word
// Configuration macro: MIPS_FETCH_PREFETCH_EN adds the PREFETCH state.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

`ifdef MIPS_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    PREFETCH = 2'd2
  } t_fetch_state;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1
  } t_fetch_state;
`endif

endpackage

// File: rtl/mips_icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
//   clk        : clock
//   invalidate : clear every valid bit at the next posedge (wins over a write)
//   rd_index   : combinational read port index
//   rd_valid, rd_tag, rd_data : contents of line rd_index
//   wr_en, wr_index, wr_tag, wr_data, wr_valid : single write port
// Tag and data contents are never reset; only the valid bits are cleared.
module mips_icache_array #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 26
) (
  input  logic                  clk,
  input  logic                  invalidate,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_r  [LINES];
  logic [31:0]         data_r [LINES];

  // Valid bits: bulk invalidate takes priority over a fill landing in the same cycle.
  always_ff @(posedge clk) begin
    if (invalidate) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= wr_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data storage, written on every fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_data  = data_r[rd_index];

endmodule

// File: rtl/mips_instr_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction buffer for mips_cpu_harvard.
//   clk, reset (sync, active-low), flush (invalidate all lines)
//   cpu_instr_address / cpu_instr_readdata / cpu_clock_enable : CPU side;
//     hits are answered combinationally in the same cycle
//   mem_address / mem_read / mem_waitrequest / mem_readdata : memory side,
//     request held until waitrequest drops
//   miss_count : saturating demand-miss counter
// Configuration macro: MIPS_FETCH_PREFETCH_EN fetches the next sequential word after
// every demand fill while the CPU keeps running on hits.
module mips_instr_fetch_cache
  import mips_fetch_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  output logic        cpu_clock_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [15:0] miss_count
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  t_fetch_state          state_r, state_s;
  logic [31:0]           mem_address_r, mem_address_s;
  logic                  mem_read_r, mem_read_s;
  logic [15:0]           miss_count_r;
  logic                  miss_s;
  logic                  fill_we_s;
  logic [31:0]           aligned_addr_s;
  logic                  is_halt_s;
  logic [INDEX_BITS-1:0] lk_index_s;
  logic [TAG_BITS-1:0]   lk_tag_s;
  logic                  rd_valid_s;
  logic [TAG_BITS-1:0]   rd_tag_s;
  logic [31:0]           rd_data_s;
  logic                  hit_line_s;
`ifdef MIPS_FETCH_PREFETCH_EN
  logic [31:0]           pf_addr_s;
`endif

  assign aligned_addr_s = cpu_instr_address & 32'hFFFF_FFFC;
  assign is_halt_s      = (aligned_addr_s == HALT_ADDR);
`ifdef MIPS_FETCH_PREFETCH_EN
  // The next sequential word; wraps naturally at 2^32.
  assign pf_addr_s      = mem_address_r + 32'd4;
`endif

  // Read-port address: the CPU PC, except during a demand fetch when the CPU is
  // stalled anyway and the port is borrowed to check whether the prefetch line is present.
  always_comb begin
    lk_index_s = aligned_addr_s[INDEX_BITS+1:2];
    lk_tag_s   = aligned_addr_s[31:INDEX_BITS+2];
`ifdef MIPS_FETCH_PREFETCH_EN
    if (state_r == FETCH) begin
      lk_index_s = pf_addr_s[INDEX_BITS+1:2];
      lk_tag_s   = pf_addr_s[31:INDEX_BITS+2];
    end else begin
      lk_index_s = aligned_addr_s[INDEX_BITS+1:2];
      lk_tag_s   = aligned_addr_s[31:INDEX_BITS+2];
    end
`endif
  end

  assign hit_line_s = rd_valid_s && (rd_tag_s == lk_tag_s);

  mips_icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .invalidate (flush || !reset),
    .rd_index   (lk_index_s),
    .rd_valid   (rd_valid_s),
    .rd_tag     (rd_tag_s),
    .rd_data    (rd_data_s),
    .wr_en      (fill_we_s),
    .wr_index   (mem_address_r[INDEX_BITS+1:2]),
    .wr_tag     (mem_address_r[31:INDEX_BITS+2]),
    .wr_data    (mem_readdata),
    .wr_valid   (!flush)
  );

  // Next-state, request and CPU-side outputs. The fill always targets the
  // address currently held on mem_address.
  always_comb begin
    state_s            = state_r;
    mem_read_s         = mem_read_r;
    mem_address_s      = mem_address_r;
    miss_s             = 1'b0;
    fill_we_s          = 1'b0;
    cpu_clock_enable   = 1'b0;
    cpu_instr_readdata = 32'h0000_0000;
    if (!reset) begin
      state_s       = IDLE;
      mem_read_s    = 1'b0;
      mem_address_s = 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_halt_s) begin
            cpu_clock_enable   = 1'b1;
            cpu_instr_readdata = 32'h0000_0000;
          end else if (hit_line_s) begin
            cpu_clock_enable   = 1'b1;
            cpu_instr_readdata = rd_data_s;
          end else begin
            miss_s        = 1'b1;
            state_s       = FETCH;
            mem_read_s    = 1'b1;
            mem_address_s = aligned_addr_s;
          end
        end
        FETCH: begin
          if (!mem_waitrequest) begin
            fill_we_s = 1'b1;
`ifdef MIPS_FETCH_PREFETCH_EN
            // A flush this cycle empties the cache, so the next line cannot be present.
            if (hit_line_s && !flush) begin
              state_s    = IDLE;
              mem_read_s = 1'b0;
            end else begin
              state_s       = PREFETCH;
              mem_read_s    = 1'b1;
              mem_address_s = pf_addr_s;
            end
`else
            state_s    = IDLE;
            mem_read_s = 1'b0;
`endif
          end else begin
            state_s = FETCH;
          end
        end
`ifdef MIPS_FETCH_PREFETCH_EN
        PREFETCH: begin
          // CPU keeps running on hits; a demand miss simply stalls until IDLE.
          if (is_halt_s) begin
            cpu_clock_enable   = 1'b1;
            cpu_instr_readdata = 32'h0000_0000;
          end else if (hit_line_s) begin
            cpu_clock_enable   = 1'b1;
            cpu_instr_readdata = rd_data_s;
          end else begin
            cpu_clock_enable   = 1'b0;
          end
          if (!mem_waitrequest) begin
            fill_we_s  = 1'b1;
            state_s    = IDLE;
            mem_read_s = 1'b0;
          end else begin
            state_s = PREFETCH;
          end
        end
`endif
        default: begin
          state_s    = IDLE;
          mem_read_s = 1'b0;
        end
      endcase
    end
  end

  // State, request registers and saturating miss counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      mem_read_r    <= 1'b0;
      mem_address_r <= 32'h0000_0000;
      miss_count_r  <= 16'h0000;
    end else begin
      state_r       <= state_s;
      mem_read_r    <= mem_read_s;
      mem_address_r <= mem_address_s;
      if (miss_s && (miss_count_r != 16'hFFFF)) begin
        miss_count_r <= miss_count_r + 16'd1;
      end else begin
        miss_count_r <= miss_count_r;
      end
    end
  end

  assign mem_read    = mem_read_r;
  assign mem_address = mem_address_r;
  assign miss_count  = miss_count_r;

endmodule
